// File: rtl/fir_tm_pkg.sv
// Shared constants for the time-multiplexed FIR sample feeder: widths, FSM codes, requantiser.
// Latency: n/a (package only).
// Build option FEEDER_SAT_EN: requantiser clamps on overflow instead of wrapping.
package fir_tm_pkg;

    // Filter and format configuration
    localparam int N          = 4;
    localparam int WI1        = 4;
    localparam int WF1        = 5;
    localparam int WIC        = 4;
    localparam int WFC        = 5;
    localparam int WOI        = 8;
    localparam int WOF        = 5;
    localparam int FIFO_DEPTH = 4;

    // Derived widths
    localparam int WX    = WI1 + WF1;
    localparam int WA    = (WI1 + WIC + N) + (WF1 + WFC);
    localparam int WO    = WOI + WOF;
    localparam int WL    = $clog2(FIFO_DEPTH) + 1;
    localparam int SHIFT = WF1 + WFC - WOF;
    localparam int WS    = WA - SHIFT;          // accumulator width after dropping fraction bits
    localparam int CNT_W = $clog2(N + 3);       // holds the N+2 window count

    // Saturation limits of the WO-bit signed result
    localparam logic [WO-1:0] OUT_MAX = {1'b0, {(WO-1){1'b1}}};
    localparam logic [WO-1:0] OUT_MIN = {1'b1, {(WO-1){1'b0}}};

    // FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // Requantise the filter accumulator: floor-shift the surplus fraction bits away, then
    // narrow the integer field. Returns {qovf, data}.
    function automatic logic [WO:0] requant(input logic [WA-1:0] acc);
        logic [WS-1:0]    sh;
        logic [WS-WO:0]   top;
        logic             qovf;
        logic [WO-1:0]    dat;
        sh   = WS'($signed(acc) >>> SHIFT);
        top  = sh[WS-1:WO-1];
        // in range only when every discarded integer bit equals the new sign bit
        qovf = !((&top) || !(|top));
`ifdef FEEDER_SAT_EN
        dat  = qovf ? (acc[WA-1] ? OUT_MIN : OUT_MAX) : sh[WO-1:0];
`else
        dat  = sh[WO-1:0];
`endif
        return {qovf, dat};
    endfunction

endpackage

// File: rtl/fir_tm_fifo.sv
// Small synchronous FIFO, W bits x DEPTH entries (DEPTH a power of 2), with occupancy level.
// Latency: head entry visible on pop_dat combinationally; a push is visible one cycle later.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
module fir_tm_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign rd_en   = pop && !empty;
    assign wr_en   = push && (!full || rd_en);
    assign pop_dat = mem[rd_ptr];

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= push_dat;
    end

    // Pointers wrap naturally at the power-of-2 depth; level tracks occupancy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !rd_en)      level <= level + LW'(1);
            else if (rd_en && !wr_en) level <= level - LW'(1);
        end
    end

endmodule

// File: rtl/fir_tm_sample_feeder.sv
// Feeds buffered samples one at a time into the time-multiplexed FIR and returns requantised results.
// Latency: result valid N+3 cycles after the launch strobe; one sample per N+5 cycles with OUT_READY high.
// Backpressure: IN_READY (registered) drops when the FIFO is full; a result holds until OUT_READY. FEEDER_SAT_EN selects clamping.
module fir_tm_sample_feeder
    import fir_tm_pkg::*;
(
    input  logic          CLK,
    input  logic          RESET,
    input  logic [WX-1:0] IN_DATA,
    input  logic          IN_VALID,
    output logic          IN_READY,
    output logic [WX-1:0] FIR_X,
    output logic          FIR_TEST,
    input  logic [WA-1:0] FIR_OUT,
    input  logic          FIR_OVF,
    output logic [WO-1:0] OUT_DATA,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic          OUT_OVF,
    output logic [WL-1:0] FIFO_LEVEL
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             ovf_acc;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WX-1:0]    fifo_dat;
    logic [WO:0]      rq;

    assign push = IN_VALID && IN_READY;
    assign pop  = (state == ST_IDLE) && !fifo_empty;
    assign rq   = requant(FIR_OUT);

    fir_tm_fifo #(
        .W     (WX),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RESET    (RESET),
        .push     (push),
        .push_dat (IN_DATA),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (FIFO_LEVEL)
    );

    // Registered ready: low whenever the level after this cycle's push/pop will be full.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            IN_READY <= 1'b0;
        end else begin
            IN_READY <= !((fifo_full && !pop) ||
                          ((FIFO_LEVEL == WL'(FIFO_DEPTH - 1)) && push && !pop));
        end
    end

    // Launch / window-count / capture / hold sequencer. FIR_X only moves on IDLE->LAUNCH
    // because the filter re-samples X on every idle cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            FIR_X     <= '0;
            FIR_TEST  <= 1'b0;
            OUT_DATA  <= '0;
            OUT_VALID <= 1'b0;
            OUT_OVF   <= 1'b0;
        end else begin
            FIR_TEST <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        FIR_X    <= fifo_dat;
                        FIR_TEST <= 1'b1;
                        state    <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    cnt     <= CNT_W'(N + 2);
                    ovf_acc <= 1'b0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    ovf_acc <= ovf_acc | FIR_OVF;
                    cnt     <= cnt - CNT_W'(1);
                    // count reaches zero on this edge: the window is complete
                    if (cnt == CNT_W'(1)) begin
                        OUT_DATA  <= rq[WO-1:0];
                        OUT_OVF   <= ovf_acc | FIR_OVF | rq[WO];
                        OUT_VALID <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tm_sample_feeder.sv
// Directed bench for fir_tm_sample_feeder: reset, requantiser table, backpressure and FIFO ordering.
// Latency: n/a.
// Backpressure: exercised via OUT_READY hold-off and a full input FIFO.
module tb_fir_tm_sample_feeder;
    import fir_tm_pkg::*;

`ifdef FEEDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [WX-1:0] IN_DATA = '0;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [WX-1:0] FIR_X;
    logic          FIR_TEST;
    logic [WA-1:0] FIR_OUT = '0;
    logic          FIR_OVF = 1'b0;
    logic [WO-1:0] OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic          OUT_OVF;
    logic [WL-1:0] FIFO_LEVEL;

    int checks = 0;
    int errors = 0;

    fir_tm_sample_feeder dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IN_DATA    (IN_DATA),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .FIR_X      (FIR_X),
        .FIR_TEST   (FIR_TEST),
        .FIR_OUT    (FIR_OUT),
        .FIR_OVF    (FIR_OVF),
        .OUT_DATA   (OUT_DATA),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_OVF    (OUT_OVF),
        .FIFO_LEVEL (FIFO_LEVEL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [WX-1:0] x;
        logic [WA-1:0] acc;
        int            ovf_at;   // cycle after launch at which FIR_OVF pulses; 0 = none
        logic [WO-1:0] exp_d;
        logic          exp_o;
    } vec_t;

    vec_t vt[11];

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic run_one(input int idx, input vec_t v);
        int k;
        int tests;
        FIR_OUT   = v.acc;
        FIR_OVF   = 1'b0;
        OUT_READY = 1'b0;
        k = 0;
        while (!IN_READY && k < 20) begin tick; k++; end
        IN_DATA  = v.x;
        IN_VALID = 1'b1;
        tick;
        IN_VALID = 1'b0;
        k = 0;
        while (!FIR_TEST && k < 20) begin tick; k++; end
        chk($sformatf("v%0d launch", idx), FIR_TEST, 1);
        chk($sformatf("v%0d fir_x", idx), FIR_X, v.x);
        tests = 0;
        k = 0;
        while (!OUT_VALID && k < 30) begin
            tick;
            k++;
            FIR_OVF = (k == v.ovf_at);
            if (FIR_TEST) tests++;
        end
        FIR_OVF = 1'b0;
        chk($sformatf("v%0d latency", idx), k, N + 3);
        chk($sformatf("v%0d extra_test", idx), tests, 0);
        chk($sformatf("v%0d out_data", idx), OUT_DATA, v.exp_d);
        chk($sformatf("v%0d out_ovf", idx), OUT_OVF, v.exp_o);
        tick;
        tick;
        chk($sformatf("v%0d hold_valid", idx), OUT_VALID, 1);
        chk($sformatf("v%0d hold_data", idx), OUT_DATA, v.exp_d);
        OUT_READY = 1'b1;
        tick;
        OUT_READY = 1'b0;
        chk($sformatf("v%0d release", idx), OUT_VALID, 0);
    endtask

    initial begin
        logic [WX-1:0] d[6];
        logic [WX-1:0] exp_q[5];
        int  k;
        int  idx;
        int  seen;
        int  bad;
        int  got;
        int  last_t;
        int  period;
        int  maxlvl;
        int  sent;
        bit  acc;

        // requantiser vectors: sample, filter output, ovf pulse cycle, expected data/flag
        vt[0]  = '{9'h020, 22'h000400, 0, 13'h0020, 1'b0};
        vt[1]  = '{9'h1E0, 22'h3FFC00, 0, 13'h1FE0, 1'b0};
        vt[2]  = '{9'h0FF, 22'h1FFFFF, 0, SAT ? 13'h0FFF : 13'h1FFF, 1'b1};
        vt[3]  = '{9'h100, 22'h200000, 0, SAT ? 13'h1000 : 13'h0000, 1'b1};
        vt[4]  = '{9'h021, 22'h000400, 3, 13'h0020, 1'b1};
        vt[5]  = '{9'h022, 22'h000400, 0, 13'h0020, 1'b0};
        vt[6]  = '{9'h001, 22'h01FFFF, 0, 13'h0FFF, 1'b0};
        vt[7]  = '{9'h002, 22'h020000, 0, SAT ? 13'h0FFF : 13'h1000, 1'b1};
        vt[8]  = '{9'h1FF, 22'h3FFFFF, 0, 13'h1FFF, 1'b0};
        vt[9]  = '{9'h180, 22'h3E0000, 0, 13'h1000, 1'b0};
        vt[10] = '{9'h055, 22'h000400, 6, 13'h0020, 1'b1};

        // ---- reset state ----
        #12;
        chk("rst in_ready", IN_READY, 0);
        chk("rst fir_test", FIR_TEST, 0);
        chk("rst out_valid", OUT_VALID, 0);
        chk("rst level", FIFO_LEVEL, 0);
        tick;
        RESET = 1'b0;
        tick;
        chk("post_rst in_ready", IN_READY, 1);

        // ---- reset asserted mid-window ----
        FIR_OUT  = 22'h000400;
        IN_VALID = 1'b1;
        IN_DATA  = 9'h033;
        tick;
        IN_DATA  = 9'h044;
        tick;
        IN_VALID = 1'b0;
        repeat (4) tick;
        chk("pre_rst fir_x", FIR_X, 9'h033);
        chk("pre_rst level", FIFO_LEVEL, 1);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_rst fir_x", FIR_X, 0);
        chk("async_rst in_ready", IN_READY, 0);
        chk("async_rst level", FIFO_LEVEL, 0);
        chk("async_rst out", {OUT_VALID, OUT_OVF, OUT_DATA, FIR_TEST}, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (OUT_VALID || FIR_TEST) seen++;
        end
        chk("after_rst no_activity", seen, 0);

        // ---- table-driven single transactions ----
        for (int i = 0; i < 11; i++) run_one(i, vt[i]);

        // ---- five back-to-back pushes with OUT_READY low ----
        d[0] = 9'h010; d[1] = 9'h011; d[2] = 9'h012;
        d[3] = 9'h013; d[4] = 9'h014; d[5] = 9'h015;
        FIR_OUT   = 22'h000400;
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        idx = 0;
        k   = 0;
        while (idx < 5 && k < 20) begin
            IN_DATA = d[idx];
            acc = IN_READY;
            tick;
            if (acc) idx++;
            k++;
        end
        IN_VALID = 1'b0;
        chk("burst accepted", idx, 5);
        chk("burst level", FIFO_LEVEL, 4);
        chk("burst in_ready", IN_READY, 0);
        k = 0;
        while (!OUT_VALID && k < 30) begin tick; k++; end
        chk("burst first_valid", OUT_VALID, 1);
        chk("burst first_data", OUT_DATA, 13'h0020);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (!OUT_VALID || OUT_DATA !== 13'h0020 || FIR_TEST) bad++;
        end
        chk("burst hold_stable", bad, 0);
        chk("burst hold_level", FIFO_LEVEL, 4);

        // ---- drain with a push offered while full; order and throughput ----
        exp_q[0] = d[1]; exp_q[1] = d[2]; exp_q[2] = d[3];
        exp_q[3] = d[4]; exp_q[4] = d[5];
        IN_DATA   = d[5];
        IN_VALID  = 1'b1;
        OUT_READY = 1'b1;
        got    = 0;
        k      = 0;
        sent   = 0;
        maxlvl = 0;
        last_t = 0;
        period = 0;
        while (got < 5 && k < 100) begin
            acc = IN_VALID && IN_READY;
            tick;
            k++;
            if (acc) begin
                sent++;
                IN_VALID = 1'b0;
                chk("refill level", FIFO_LEVEL, 4);
            end
            if (int'(FIFO_LEVEL) > maxlvl) maxlvl = int'(FIFO_LEVEL);
            if (FIR_TEST) begin
                chk($sformatf("order %0d", got), FIR_X, exp_q[got]);
                if (got == 2) period = k - last_t;
                last_t = k;
                got++;
            end
        end
        IN_VALID = 1'b0;
        chk("drain count", got, 5);
        chk("refill accepted", sent, 1);
        chk("max level", maxlvl, 4);
        chk("throughput period", period, N + 5);
        repeat (20) tick;
        chk("drain level", FIFO_LEVEL, 0);
        chk("drain valid", OUT_VALID, 0);
        OUT_READY = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
